demux_1x16_rr_sched: RTL and testbench
======================================

// Module: demux_1x16_rr_sched
// PURPOSE
//  Round-robin slot scheduler for the 1-to-16 demultiplexer path. It drives select
//  lines sel[3:0] (-> s3..s0) and data line dmx_i (-> i) of the external demux,
//  taking serial bits from an upstream valid/ready source.
//  Each bit goes to the next enabled channel in circular order. It mirrors the last
//  bit sent to each channel in y_q. It sits between the serial bit source and the
//  demux tree.
// PARAMETERS
//  DWELL  4  accepted bits per channel slot before advancing (>=1)
//  CW     3  dwell counter width; must satisfy 2**CW >= DWELL
// PORTS
//  clk        in   1   single rising-edge clock
//  rst_n      in   1   synchronous, active-low reset (sampled on clk rising edge only)
//  start      in   1   begin scheduling; honoured in IDLE only
//  stop       in   1   request stop; latched, takes effect at end of current slot
//  ch_en      in   16  channel enable mask, bit k = channel k
//  in_valid   in   1   upstream bit valid
//  in_bit     in   1   upstream data bit
//  in_ready   out  1   scheduler accepts bit this cycle
//  sel        out  4   demux select {s3,s2,s1,s0}, registered
//  dmx_i      out  1   demux data = in_valid & in_ready & in_bit (combinational)
//  y_q        out  16  last bit delivered per channel, registered
//  busy       out  1   state != IDLE
//  frame_done out  1   1-cycle pulse: scheduler wrapped past highest enabled channel
// BEHAVIOUR
//  Reset values: in_ready=0, sel=0, y_q=0, busy=0, frame_done=0.
//  Reset internals: state=IDLE, ptr=0, ptr_vld=0, cnt=0, stop_l=0.
//  Reset mid-operation aborts the slot; no partial state survives.
//  FSM states: IDLE, SEEK, DRIVE. Accept = in_valid & in_ready.
//  IDLE:
//   - in_ready=0.
//   - start=1 and ch_en!=0 -> SEEK; clear ptr_vld and stop_l.
//   - start with ch_en==0 is ignored.
//  SEEK (exactly 1 cycle, in_ready=0):
//   - Search ch_en circularly from ptr+1 (from 0 when ptr_vld=0). First set bit = nxt.
//   - ch_en==0 here -> IDLE; sel is held.
//   - Otherwise sel<=nxt, cnt<=0, -> DRIVE.
//   - frame_done=1 iff ptr_vld=1 and nxt<=ptr. A single enabled channel pulses every slot.
//  DRIVE:
//   - in_ready=1.
//   - On accept: y_q[sel]<=in_bit and cnt<=cnt+1.
//   - On accept with cnt==DWELL-1: ptr<=sel, ptr_vld<=1.
//     - stop_l or stop set -> IDLE.
//     - Otherwise -> SEEK.
//   - No accept: hold state and cnt; in_valid may idle indefinitely.
//  Latency:
//   - start at cycle t: SEEK at t+1, in_ready first high at t+2.
//   - Slot-to-slot gap is 1 bubble cycle (SEEK).
//  stop_l: set by stop in SEEK/DRIVE. A stop in the same cycle as the final accept
//   also ends in IDLE.
//  ch_en is sampled only in SEEK; changes mid-slot apply to the next slot.
//  start while busy is ignored.
//  Wrap: ptr=15 searches from 0. nxt==ptr is allowed (only that channel enabled).
// STRUCTURE
//  Shared package demux_sched_pkg:
//   - state enum {IDLE, SEEK, DRIVE}
//   - NUM_CH=16, SEL_W=4
//  Sub-module rr_next_channel: combinational priority search.
//   - Inputs: mask[15:0], base[3:0], base_vld.
//   - Outputs: nxt[3:0], found, wrapped.
//  Top holds the FSM, cnt, ptr, stop_l and the y_q registers.
// TESTING
//  1. Reset then start, ch_en=FFFF, in_valid=1, DWELL=4:
//     - sel steps 0,1,..,15,0 with 4 accepts each and 1 bubble between slots.
//     - frame_done pulses in the SEEK where sel goes 15->0.
//  2. ch_en=8421, in_bit toggling:
//     - sel visits 0,5,10,15 only.
//     - y_q holds the last bit at bits 0,5,10,15; all other bits stay 0.
//  3. ch_en=0010:
//     - sel stays 4.
//     - frame_done pulses in every SEEK after the first.
//  4. stop asserted mid-slot on channel 3:
//     - Slot finishes its 4 accepts, then IDLE.
//     - busy=0 and in_ready=0 on the next cycle.
//     - start restarts from channel 0.
//  5. in_valid gated 1-of-3 cycles:
//     - cnt and sel hold between accepts.
//     - Exactly DWELL bits per channel; dmx_i is 1 only on accepted in_bit=1.
//  6. rst_n=0 for 1 cycle mid-DRIVE:
//     - Next cycle all outputs equal reset values.
//     - A later start begins at channel 0 with no frame_done.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared definitions for the 1-to-16 demux round-robin scheduler.
//   state_t : scheduler FSM states (IDLE, SEEK, DRIVE)
//   NUM_CH  : number of demux output channels
//   SEL_W   : width of the demux select bus
package demux_sched_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_next_channel.sv
// Combinational circular priority search over the channel enable mask.
//   mask     in  : channel enable mask, bit k = channel k
//   base     in  : last channel served
//   base_vld in  : base is meaningful; when low the search starts at channel 0
//   nxt      out : first enabled channel at or after the search start (circular)
//   found    out : mask has at least one enabled channel
//   wrapped  out : base_vld and nxt <= base (search went past channel 15 or
//                  landed back on the same channel)
module rr_next_channel
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  base,
    input  logic              base_vld,
    output logic [SEL_W-1:0]  nxt,
    output logic              found,
    output logic              wrapped
);

    logic [SEL_W-1:0]  first;
    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  offs;

    // 4-bit addition wraps 15 -> 0 naturally.
    assign first = base_vld ? (base + SEL_W'(1)) : '0;

    // Rotate the mask so rot[0] is the search start; a plain lowest-set-bit
    // search over rot then gives the circular order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign rot[gi] = mask[first + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        offs  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                offs  = SEL_W'(i);
            end
        end
    end

    assign nxt     = first + offs;
    assign wrapped = found && base_vld && (nxt <= base);

endmodule

// File: rtl/demux_1x16_rr_sched.sv
// Round-robin slot scheduler feeding an external 1-to-16 demultiplexer.
// Serial bits from a valid/ready source are steered DWELL bits at a time to
// each enabled channel in circular order; one SEEK bubble separates slots.
//   clk        in  : rising-edge clock
//   rst_n      in  : synchronous active-low reset
//   start      in  : begin scheduling (IDLE only, needs ch_en != 0)
//   stop       in  : stop at the end of the current slot (latched)
//   ch_en      in  : channel enable mask, sampled in SEEK
//   in_valid   in  : upstream bit valid
//   in_bit     in  : upstream data bit
//   in_ready   out : bit accepted this cycle when in_valid is high
//   sel        out : demux select {s3,s2,s1,s0}, registered
//   dmx_i      out : demux data = in_valid & in_ready & in_bit
//   y_q        out : last bit delivered per channel, registered
//   busy       out : scheduler not idle
//   frame_done out : pulse in the SEEK that wraps past the highest channel
module demux_1x16_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              dmx_i,
    output logic [NUM_CH-1:0] y_q,
    output logic              busy,
    output logic              frame_done
);

    state_t            state_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic              ptr_vld_reg;
    logic [CW-1:0]     cnt_reg;
    logic              stop_l_reg;
    logic [NUM_CH-1:0] y_q_reg;

    logic [SEL_W-1:0]  nxt;
    logic              found;
    logic              wrapped;
    logic              accept;
    logic              last_beat;

    rr_next_channel u_next (
        .mask     (ch_en),
        .base     (ptr_reg),
        .base_vld (ptr_vld_reg),
        .nxt      (nxt),
        .found    (found),
        .wrapped  (wrapped)
    );

    assign accept    = in_valid && (state_reg == DRIVE);
    assign last_beat = (cnt_reg == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_reg     <= '0;
            ptr_reg     <= '0;
            ptr_vld_reg <= 1'b0;
            cnt_reg     <= '0;
            stop_l_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && (ch_en != '0)) begin
                        state_reg   <= SEEK;
                        ptr_vld_reg <= 1'b0;
                        stop_l_reg  <= 1'b0;
                    end
                end
                SEEK: begin
                    if (stop) stop_l_reg <= 1'b1;
                    if (!found) begin
                        // Mask emptied since start: give up, keep sel as is.
                        state_reg <= IDLE;
                    end else begin
                        sel_reg   <= nxt;
                        cnt_reg   <= '0;
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (stop) stop_l_reg <= 1'b1;
                    if (accept) begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (last_beat) begin
                            ptr_reg     <= sel_reg;
                            ptr_vld_reg <= 1'b1;
                            // A stop arriving with the final bit still ends here.
                            state_reg   <= (stop_l_reg || stop) ? IDLE : SEEK;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-channel mirror of the last delivered bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_yq
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    y_q_reg[gi] <= 1'b0;
                end else if (accept && (sel_reg == SEL_W'(gi))) begin
                    y_q_reg[gi] <= in_bit;
                end
            end
        end
    endgenerate

    assign in_ready   = (state_reg == DRIVE);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == SEEK) && wrapped;
    assign dmx_i      = in_valid && in_ready && in_bit;
    assign sel        = sel_reg;
    assign y_q        = y_q_reg;

endmodule

// File: tb/tb_demux_1x16_rr_sched.sv
// Self-checking bench for demux_1x16_rr_sched. A transaction-level model
// tracks which channel each slot should serve, the accepted-bit count per
// slot, the expected SEEK bubble timing and the per-channel last bit.
module tb_demux_1x16_rr_sched;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] ch_en = '0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_ready;
    logic [3:0]  sel;
    logic        dmx_i;
    logic [15:0] y_q;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    logic [15:0] ymodel = '0;

    demux_1x16_rr_sched #(.DWELL(DWELL), .CW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .ch_en      (ch_en),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .sel        (sel),
        .dmx_i      (dmx_i),
        .y_q        (y_q),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Next enabled channel in circular order after 'from', or from 0 when
    // nothing has been served yet. Returns -1 for an empty mask.
    function automatic int next_en(input logic [15:0] m, input int from, input bit vld);
        int c;
        for (int k = 0; k < 16; k++) begin
            c = vld ? (from + 1 + k) % 16 : k;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ymodel = '0;
    endtask

    // Start the scheduler, run nslots complete slots with random data and
    // in_valid high vpct percent of the time, and check every cycle.
    // stop_slot >= 0 raises stop for one cycle mid-way through that slot.
    task automatic run_slots(input logic [15:0] mask, input int nslots,
                             input int vpct, input int stop_slot, input string tag);
        int  slot = 0, acc = 0, cur, prev = 0, cyc = 0;
        bit  prev_vld = 0, seek_due = 1, exp_rdy, exp_fd;
        @(negedge clk);
        start = 1'b1; ch_en = mask; in_valid = 1'b0; stop = 1'b0;
        cur = next_en(mask, 0, 0);
        while (slot < nslots) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = ($urandom_range(99) < vpct);
            in_bit   = 1'($urandom);
            stop     = (slot == stop_slot) && (acc == 1) && !seek_due;
            #1;
            exp_rdy = !seek_due;
            exp_fd  = seek_due && prev_vld && (cur <= prev);
            total += 4;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL %s in_ready slot=%0d got=%b want=%b", tag, slot, in_ready, exp_rdy);
            end
            if (busy !== 1'b1) begin
                bad++; $display("FAIL %s busy slot=%0d got=%b want=1", tag, slot, busy);
            end
            if (frame_done !== exp_fd) begin
                bad++; $display("FAIL %s frame_done slot=%0d got=%b want=%b", tag, slot, frame_done, exp_fd);
            end
            if (dmx_i !== (in_valid & exp_rdy & in_bit)) begin
                bad++; $display("FAIL %s dmx_i slot=%0d got=%b want=%b", tag, slot, dmx_i, in_valid & exp_rdy & in_bit);
            end
            if (exp_rdy) begin
                total++;
                if (sel !== 4'(cur)) begin
                    bad++; $display("FAIL %s sel slot=%0d got=%0d want=%0d", tag, slot, sel, cur);
                end
                if (in_valid) begin
                    ymodel[cur] = in_bit;
                    acc++;
                    if (acc == DWELL) begin
                        $display("slot %s #%0d ch=%0d done", tag, slot, cur);
                        acc = 0; slot++; prev = cur; prev_vld = 1;
                        cur = next_en(mask, prev, 1);
                        seek_due = 1;
                    end
                end
            end else begin
                seek_due = 0;
            end
            cyc++;
            if (cyc > 5000) begin
                bad++; $display("FAIL %s timeout slot=%0d got=running want=done", tag, slot);
                break;
            end
        end
        // Cycle after the final accept: SEEK with its frame_done, or IDLE on stop.
        @(negedge clk);
        in_valid = 1'b0; stop = 1'b0;
        #1;
        exp_fd = (stop_slot < 0) && prev_vld && (cur <= prev);
        total += 4;
        if (busy !== (stop_slot < 0)) begin
            bad++; $display("FAIL %s end_busy got=%b want=%b", tag, busy, stop_slot < 0);
        end
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL %s end_in_ready got=%b want=0", tag, in_ready);
        end
        if (frame_done !== exp_fd) begin
            bad++; $display("FAIL %s end_frame_done got=%b want=%b", tag, frame_done, exp_fd);
        end
        if (y_q !== ymodel) begin
            bad++; $display("FAIL %s y_q got=%h want=%h", tag, y_q, ymodel);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({in_ready, sel, y_q, busy, frame_done} !== 23'd0) begin
            bad++;
            $display("FAIL %s reset_outputs got rdy=%b sel=%0d y_q=%h busy=%b fd=%b want all 0",
                     tag, in_ready, sel, y_q, busy, frame_done);
        end
        $display("check %s reset outputs", tag);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        ymodel = '0;
    endtask

    task automatic test_start_empty();
        @(negedge clk);
        start = 1'b1; ch_en = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL start_empty busy got=%b want=0", busy);
        end
        $display("check start with empty mask");
    endtask

    task automatic test_full_ring();
        pulse_reset();
        run_slots(16'hFFFF, 17, 100, -1, "ring");
    endtask

    task automatic test_sparse();
        pulse_reset();
        run_slots(16'h8421, 9, 100, -1, "sparse");
    endtask

    task automatic test_single();
        pulse_reset();
        run_slots(16'h0010, 5, 100, -1, "single");
    endtask

    task automatic test_stop();
        pulse_reset();
        run_slots(16'hFFFF, 4, 100, 3, "stop");
        run_slots(16'hFFFF, 3, 100, -1, "restart");
    endtask

    task automatic test_gated();
        pulse_reset();
        run_slots(16'hFFFF, 5, 33, -1, "gated");
        pulse_reset();
        run_slots(16'hA5C3, 10, 50, -1, "gated_mask");
    endtask

    task automatic test_random_masks();
        logic [15:0] m;
        for (int r = 0; r < 4; r++) begin
            m = 16'($urandom);
            if (m == '0) m = 16'h0001;
            pulse_reset();
            run_slots(m, 8, 70, -1, "rand_mask");
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        run_slots(16'hFFFF, 1, 100, -1, "pre_rst");
        @(negedge clk);
        in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        ymodel = '0;
        run_slots(16'hFFFF, 2, 100, -1, "post_rst");
    endtask

    initial begin
        test_reset();
        test_start_empty();
        test_full_ring();
        test_sparse();
        test_single();
        test_stop();
        test_gated();
        test_random_masks();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
